// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational on lk_pc; updates from the mem stage land on
// the rising edge of CLK. No write-through: a same-cycle lookup sees the
// pre-edge contents of the entry.
module branch_target_buffer #(
  parameter int ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lk_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  pred_index,
  input  logic        upd_en,
  input  logic [1:0]  upd_index,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_all
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic [ENTRIES-1:0]        valid_q, valid_d;
  logic [ENTRIES-1:0][27:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]  target_q, target_d;
  logic [ENTRIES-1:0][1:0]   ctr_q, ctr_d;

  logic lk_hit;
  logic upd_hit;

  // The low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[3:0]};

  // Combinational lookup into the entry selected by lk_pc[3:2].
  always_comb begin
    pred_index  = lk_pc[3:2];
    lk_hit      = valid_q[lk_pc[3:2]] && (tag_q[lk_pc[3:2]] == lk_pc[31:4]);
    pred_taken  = lk_hit && ctr_q[lk_pc[3:2]][1];
    pred_target = pred_taken ? target_q[lk_pc[3:2]] : (lk_pc + 32'd4);
  end

  // Next-state for the table: flush wins over update; a not-taken miss is a no-op.
  // upd_index is trusted as delivered by the pipeline, not rederived from upd_pc.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    upd_hit  = valid_q[upd_index] && (tag_q[upd_index] == upd_pc[31:4]);
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_index] != 2'b11) ctr_d[upd_index] = ctr_q[upd_index] + 2'b01;
          target_d[upd_index] = upd_target;
        end else begin
          if (ctr_q[upd_index] != 2'b00) ctr_d[upd_index] = ctr_q[upd_index] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_d[upd_index]  = 1'b1;
        tag_d[upd_index]    = upd_pc[31:4];
        target_d[upd_index] = upd_target;
        ctr_d[upd_index]    = CTR_ALLOC;
      end
    end
  end

  // Table registers; asynchronous reset drops any in-flight write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{CTR_RESET}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against a behavioural
// table model held in plain arrays.
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_index;
  logic        upd_en;
  logic [1:0]  upd_index;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_all;

  branch_target_buffer #(.ENTRIES(4)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .lk_pc       (lk_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_index  (pred_index),
    .upd_en      (upd_en),
    .upd_index   (upd_index),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush_all   (flush_all)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per entry, counter as a plain integer 0..3.
  bit          m_valid[4];
  logic [27:0] m_tag[4];
  logic [31:0] m_target[4];
  int          m_ctr[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic model_edge(input bit en, input logic [1:0] idx, input logic [31:0] pc,
                            input bit tk, input logic [31:0] tgt, input bit fl);
    int i;
    i = int'(idx);
    if (fl) begin
      for (int k = 0; k < 4; k++) m_valid[k] = 0;
    end else if (en) begin
      if (m_valid[i] && m_tag[i] == pc[31:4]) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = pc[31:4]; m_target[i] = tgt; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against the model for the current lk_pc.
  task automatic check_lookup(input string tag);
    int i;
    bit hit, tk;
    logic [31:0] tgt;
    i   = int'(lk_pc[3:2]);
    hit = m_valid[i] && (m_tag[i] == lk_pc[31:4]);
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_target[i] : lk_pc + 32'd4;
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, ".target"}, pred_target, tgt);
    chk({tag, ".index"},  {30'd0, pred_index}, i[31:0]);
  endtask

  // Drive one update cycle starting from a falling edge; model steps on the rising edge.
  task automatic do_cycle(input bit en, input logic [1:0] idx, input logic [31:0] pc,
                          input bit tk, input logic [31:0] tgt, input bit fl);
    upd_en = en; upd_index = idx; upd_pc = pc; upd_taken = tk; upd_target = tgt; flush_all = fl;
    @(posedge CLK);
    model_edge(en, idx, pc, tk, tgt, fl);
    #1;
    upd_en = 0; flush_all = 0;
    @(negedge CLK);
  endtask

  task automatic look(input logic [31:0] pc, input string tag);
    lk_pc = pc;
    #1;
    check_lookup(tag);
  endtask

  initial begin
    // Reset, asynchronous, applied at time zero.
    nRST = 0; lk_pc = 32'h40; upd_en = 0; upd_index = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; flush_all = 0;
    model_reset();
    #1;
    chk("in_reset.taken", {31'd0, pred_taken}, 32'd0);
    chk("in_reset.target", pred_target, 32'h44);
    repeat (2) @(negedge CLK);
    nRST = 1;

    // Reset state lookup.
    lk_pc = 32'h0000_0040; #1;
    chk("rst.taken", {31'd0, pred_taken}, 32'd0);
    chk("rst.target", pred_target, 32'h0000_0044);
    chk("rst.index", {30'd0, pred_index}, 32'd0);
    look(32'h0000_0000, "rst_pc0");
    look(32'hFFFF_FFFC, "wrap");
    chk("wrap.const", pred_target, 32'h0000_0000);

    // Allocate and hit.
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_0200, 0);
    look(32'h0000_0104, "alloc_hit");
    chk("alloc_hit.const_t", {31'd0, pred_taken}, 32'd1);
    chk("alloc_hit.const_tgt", pred_target, 32'h0000_0200);
    look(32'h0000_0204, "alloc_tagmiss");
    chk("tagmiss.const_tgt", pred_target, 32'h0000_0208);

    // Counter walk: NT, NT, T, T, T, T, then NT shows saturation at 11.
    lk_pc = 32'h0000_0104;
    do_cycle(1, 2'd1, 32'h0000_0104, 0, 32'h0, 0);
    look(32'h0000_0104, "walk_nt1");
    chk("walk_nt1.const", {31'd0, pred_taken}, 32'd0);
    do_cycle(1, 2'd1, 32'h0000_0104, 0, 32'h0, 0); look(32'h0000_0104, "walk_nt2");
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_0300, 0); look(32'h0000_0104, "walk_t1");
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_0304, 0); look(32'h0000_0104, "walk_t2");
    chk("walk_t2.const", {31'd0, pred_taken}, 32'd1);
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_0308, 0); look(32'h0000_0104, "walk_t3");
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_030C, 0); look(32'h0000_0104, "walk_t4");
    do_cycle(1, 2'd1, 32'h0000_0104, 0, 32'h0, 0); look(32'h0000_0104, "walk_sat");
    chk("walk_sat.const", {31'd0, pred_taken}, 32'd1);

    // Not-taken miss to an invalid entry leaves it invalid.
    do_cycle(1, 2'd3, 32'h0000_000C, 0, 32'h0000_0800, 0);
    look(32'h0000_000C, "nt_miss");

    // Same-cycle lookup/update of entry 2.
    do_cycle(1, 2'd2, 32'h0000_0308, 1, 32'h0000_0400, 0);
    lk_pc = 32'h0000_0308;
    upd_en = 1; upd_index = 2'd2; upd_pc = 32'h0000_0308; upd_taken = 1;
    upd_target = 32'h0000_0500; flush_all = 0;
    #1; check_lookup("same_old");
    chk("same_old.const", pred_target, 32'h0000_0400);
    @(posedge CLK);
    model_edge(1, 2'd2, 32'h0000_0308, 1, 32'h0000_0500, 0);
    #1; upd_en = 0;
    check_lookup("same_new");
    chk("same_new.const", pred_target, 32'h0000_0500);
    @(negedge CLK);

    // Flush together with an allocating update: everything invalid afterwards.
    do_cycle(1, 2'd0, 32'h0000_1000, 1, 32'h0000_2000, 1);
    look(32'h0000_1000, "flush_e0");
    look(32'h0000_0104, "flush_e1");
    look(32'h0000_0308, "flush_e2");

    // Mid-operation reset with an allocation pending.
    do_cycle(1, 2'd1, 32'h0000_0104, 1, 32'h0000_0600, 0);
    look(32'h0000_0104, "pre_rst_hit");
    upd_en = 1; upd_index = 2'd3; upd_pc = 32'h0000_00FC; upd_taken = 1;
    upd_target = 32'h0000_0700;
    #2 nRST = 0;
    model_reset();
    #1;
    chk("midrst.taken", {31'd0, pred_taken}, 32'd0);
    check_lookup("midrst");
    upd_en = 0;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK); #1;
    look(32'h0000_00FC, "midrst_noalloc");
    look(32'h0000_0104, "midrst_e1");
    @(negedge CLK);

    // Randomized traffic over a small tag pool so hits and conflicts are common.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, lpc, tgt;
      logic [1:0]  idx;
      bit en, tk, fl;
      pc  = (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      lpc = ($urandom_range(0, 15) == 0) ? $urandom :
            ((32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2));
      tgt = $urandom;
      idx = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : pc[3:2];
      en  = $urandom_range(0, 3) != 0;
      tk  = $urandom_range(0, 1) == 1;
      fl  = $urandom_range(0, 24) == 0;
      lk_pc = lpc;
      upd_en = en; upd_index = idx; upd_pc = pc; upd_taken = tk; upd_target = tgt; flush_all = fl;
      #1; check_lookup("rand_pre");
      @(posedge CLK);
      model_edge(en, idx, pc, tk, tgt, fl);
      #1; upd_en = 0; flush_all = 0;
      check_lookup("rand_post");
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
